// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read/write channel arbiters.
// Slave map: S0 at ARADDR[31:16]=0x0000, S1 at 0x0001, all else default slave.
package axi_arb_pkg;

    localparam int AXI_ADDR_HI_W = 16;
    localparam int AXI_LEN_BITS  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_AR   = 2'd1,
        ARB_R    = 2'd2
    } arb_state_e;

    localparam logic [1:0] SEL_S0  = 2'b00;
    localparam logic [1:0] SEL_S1  = 2'b01;
    localparam logic [1:0] SEL_DEF = 2'b10;

    localparam logic [AXI_ADDR_HI_W-1:0] SLV0_BASE = 16'h0000;
    localparam logic [AXI_ADDR_HI_W-1:0] SLV1_BASE = 16'h0001;

    function automatic logic [1:0] sel_decode(
        input logic [AXI_ADDR_HI_W-1:0] addr_hi
    );
        logic [1:0] sel;
        sel = SEL_DEF;
        if (addr_hi == SLV0_BASE) sel = SEL_S0;
        else if (addr_hi == SLV1_BASE) sel = SEL_S1;
        return sel;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arb2.sv
// Two-requester round-robin picker; the pointer names the favoured
// requester on a tie and moves only when the owner strobes upd.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_vld = |req;
        gnt_idx = (&req) ? ptr_q : req[1];
        ptr_d   = ptr_q;
        if (upd) ptr_d = ~upd_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Read-path arbiter for the 2x2 AXI crossbar: RR grant, decode, beat check.
// Define READ_ARB_TIMEOUT_EN to add the idle-beat watchdog (arb_timeout).
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_HI_W   = AXI_ADDR_HI_W,
    parameter int LEN_W       = AXI_LEN_BITS,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ARVALID_M0,
    input  logic                 ARVALID_M1,
    input  logic [ADDR_HI_W-1:0] ARADDR_HI_M0,
    input  logic [ADDR_HI_W-1:0] ARADDR_HI_M1,
    input  logic [LEN_W-1:0]     ARLEN_M0,
    input  logic [LEN_W-1:0]     ARLEN_M1,
    input  logic                 ARREADY_SEL,
    input  logic                 RVALID_SEL,
    input  logic                 RLAST_SEL,
    input  logic                 RREADY_GNT,
    output logic                 grant_m0,
    output logic                 grant_m1,
    output logic [1:0]           slave_sel,
    output logic                 ar_en,
    output logic                 r_en,
    output logic [LEN_W-1:0]     beat_cnt,
    output logic                 err_len,
    output logic                 arb_timeout
);

    arb_state_e       state_q, state_d;
    logic             mst_q, mst_d;
    logic [1:0]       sel_q, sel_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             ar_en_q, ar_en_d;
    logic             r_en_q, r_en_d;
    logic             err_q, err_d;

    logic             pick_vld, pick_idx;
    logic             upd;
    logic             ar_hs, r_hs, done;

`ifdef READ_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
`endif

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({ARVALID_M1, ARVALID_M0}),
        .upd     (upd),
        .upd_idx (mst_q),
        .gnt_vld (pick_vld),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        mst_d   = mst_q;
        sel_d   = sel_q;
        len_d   = len_q;
        beat_d  = beat_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        ar_en_d = ar_en_q;
        r_en_d  = r_en_q;
        err_d   = 1'b0;
        upd     = 1'b0;
        done    = 1'b0;
        ar_hs   = (mst_q ? ARVALID_M1 : ARVALID_M0) && ARREADY_SEL;
        r_hs    = RVALID_SEL && RREADY_GNT;
`ifdef READ_ARB_TIMEOUT_EN
        wd_d    = '0;
        to_d    = 1'b0;
`endif

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_AR;
                    mst_d   = pick_idx;
                    sel_d   = sel_decode(pick_idx ? ARADDR_HI_M1
                                                  : ARADDR_HI_M0);
                    len_d   = pick_idx ? ARLEN_M1 : ARLEN_M0;
                    gnt0_d  = ~pick_idx;
                    gnt1_d  = pick_idx;
                    ar_en_d = 1'b1;
                    beat_d  = '0;
                end
            end
            ARB_AR: begin
                if (ar_hs) begin
                    state_d = ARB_R;
                    ar_en_d = 1'b0;
                    r_en_d  = 1'b1;
                    beat_d  = '0;
                end
            end
            ARB_R: begin
                if (r_hs) begin
                    if (RLAST_SEL) begin
                        err_d = (beat_q != len_q);
                        done  = 1'b1;
                    end else if (beat_q != '1) begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

`ifdef READ_ARB_TIMEOUT_EN
        if (state_q != ARB_IDLE) begin
            if ((state_q == ARB_AR && ar_hs) || (state_q == ARB_R && r_hs))
                wd_d = '0;
            else if (wd_q == WD_MAX && !done) begin
                to_d = 1'b1;
                done = 1'b1;
            end else
                wd_d = wd_q + 1'b1;
        end
`endif

        // Burst end (RLAST or watchdog): release the path, hand priority over.
        if (done) begin
            upd     = 1'b1;
            state_d = ARB_IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            ar_en_d = 1'b0;
            r_en_d  = 1'b0;
            sel_d   = SEL_S0;
            beat_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            mst_q   <= 1'b0;
            sel_q   <= SEL_S0;
            len_q   <= '0;
            beat_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ar_en_q <= 1'b0;
            r_en_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef READ_ARB_TIMEOUT_EN
            wd_q    <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mst_q   <= mst_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            ar_en_q <= ar_en_d;
            r_en_q  <= r_en_d;
            err_q   <= err_d;
`ifdef READ_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
            to_q    <= to_d;
`endif
        end
    end

    assign grant_m0  = gnt0_q;
    assign grant_m1  = gnt1_q;
    assign slave_sel = sel_q;
    assign ar_en     = ar_en_q;
    assign r_en      = r_en_q;
    assign beat_cnt  = beat_q;
    assign err_len   = err_q;
`ifdef READ_ARB_TIMEOUT_EN
    assign arb_timeout = to_q;
`else
    assign arb_timeout = 1'b0;
`endif

endmodule
